// File: rtl/pulse_meas.sv
// Two-channel pulse-width meter: measures high time per channel and queues {ch, width} records.
// Optional capture timestamps are enabled by defining PULSE_MEAS_TIMESTAMP_EN.
module pulse_meas #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       din,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic             rec_ch,
  output logic [CNT_W-1:0] rec_width,
`ifdef PULSE_MEAS_TIMESTAMP_EN
  output logic [CNT_W-1:0] rec_ts,
`endif
  output logic             ovf,
  input  logic             clr_ovf
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    IDLE = 1'b0,
    HIGH = 1'b1
  } state_t;

  state_t           state [2];
  logic [1:0]       d1;
  logic [1:0]       rise;
  logic [1:0]       fall;
  logic [1:0]       push;
  logic [CNT_W-1:0] cnt [2];

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    slot1;
  logic [CW-1:0]    count;
  logic [CW-1:0]    free;
  logic             pop;
  logic             acc0;
  logic             acc1;
  logic             drop;

  logic             mem_ch [DEPTH];
  logic [CNT_W-1:0] mem_w  [DEPTH];

  assign rise = din & ~d1;
  assign fall = ~din & d1;

  // Per-channel measurement FSM; a record is emitted on the falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      d1 <= '0;
      for (int i = 0; i < 2; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      d1 <= din;
      for (int i = 0; i < 2; i++) begin
        case (state[i])
          IDLE: begin
            if (rise[i]) begin
              state[i] <= HIGH;
              cnt[i]   <= CNT_W'(1);
            end
          end
          HIGH: begin
            if (fall[i]) begin
              state[i] <= IDLE;
            end else if (cnt[i] != CNT_MAX) begin
              cnt[i] <= cnt[i] + CNT_W'(1);
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      push[i] = (state[i] == HIGH) && fall[i];
    end
  end

  // Space accounting includes this cycle's pop; ch0 takes the first free slot.
  assign pop   = rec_valid & rec_ready;
  assign free  = CW'(DEPTH) - count + CW'(pop);
  assign acc0  = push[0] & (free != '0);
  assign acc1  = push[1] & (push[0] ? (free >= CW'(2)) : (free != '0));
  assign drop  = (push[0] & ~acc0) | (push[1] & ~acc1);
  assign slot1 = acc0 ? wr_ptr + AW'(1) : wr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(acc0) + AW'(acc1);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(acc0) + CW'(acc1) - CW'(pop);
      if (drop) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc0) begin
      mem_ch[wr_ptr] <= 1'b0;
      mem_w[wr_ptr]  <= cnt[0];
    end
    if (acc1) begin
      mem_ch[slot1] <= 1'b1;
      mem_w[slot1]  <= cnt[1];
    end
  end

  assign rec_valid = (count != '0);
  assign rec_ch    = rec_valid & mem_ch[rd_ptr];
  assign rec_width = rec_valid ? mem_w[rd_ptr] : '0;

`ifdef PULSE_MEAS_TIMESTAMP_EN
  logic [CNT_W-1:0] ts_cnt;
  logic [CNT_W-1:0] ts_cap [2];
  logic [CNT_W-1:0] mem_ts [DEPTH];

  // Free-running cycle counter, sampled into the channel's capture register on rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt <= '0;
      for (int i = 0; i < 2; i++) begin
        ts_cap[i] <= '0;
      end
    end else begin
      ts_cnt <= ts_cnt + CNT_W'(1);
      for (int i = 0; i < 2; i++) begin
        if (rise[i]) begin
          ts_cap[i] <= ts_cnt;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc0) begin
      mem_ts[wr_ptr] <= ts_cap[0];
    end
    if (acc1) begin
      mem_ts[slot1] <= ts_cap[1];
    end
  end

  assign rec_ts = rec_valid ? mem_ts[rd_ptr] : '0;
`endif

endmodule

// File: tb/tb_pulse_meas.sv
// Bench for pulse_meas: a CNT_W=16 and a CNT_W=4 instance share stimulus and are checked
// each cycle against a run-length / record-queue reference model.
module tb_pulse_meas;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  din;
  logic        rec_ready;
  logic        clr_ovf;

  logic        valid_a, ch_a, ovf_a;
  logic [15:0] w_a;
  logic        valid_b, ch_b, ovf_b;
  logic [3:0]  w_b;
`ifdef PULSE_MEAS_TIMESTAMP_EN
  logic [15:0] ts_a;
  logic [3:0]  ts_b;
`endif

  always #5 clk = ~clk;

  pulse_meas #(.CNT_W(16), .DEPTH(DEPTH)) u_dut_a (
    .clk(clk), .rst(rst), .din(din),
    .rec_valid(valid_a), .rec_ready(rec_ready), .rec_ch(ch_a), .rec_width(w_a),
`ifdef PULSE_MEAS_TIMESTAMP_EN
    .rec_ts(ts_a),
`endif
    .ovf(ovf_a), .clr_ovf(clr_ovf)
  );

  pulse_meas #(.CNT_W(4), .DEPTH(DEPTH)) u_dut_b (
    .clk(clk), .rst(rst), .din(din),
    .rec_valid(valid_b), .rec_ready(rec_ready), .rec_ch(ch_b), .rec_width(w_b),
`ifdef PULSE_MEAS_TIMESTAMP_EN
    .rec_ts(ts_b),
`endif
    .ovf(ovf_b), .clr_ovf(clr_ovf)
  );

  typedef struct {
    bit ch;
    int w;
    int ts;
  } rec_t;

  rec_t q[$];
  int   run   [2];
  bit   prev  [2];
  int   start [2];
  int   cyc;
  bit   m_ovf;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Reference: count consecutive high samples, emit on the first low sample, bounded queue.
  task automatic model_update();
    bit   ended [2];
    rec_t r   [2];
    bit   do_pop;
    bit   dropped;
    if (rst) begin
      q.delete();
      for (int c = 0; c < 2; c++) begin
        run[c] = 0; prev[c] = 0; start[c] = 0;
      end
      cyc   = 0;
      m_ovf = 0;
      return;
    end
    do_pop = (q.size() > 0) && rec_ready;
    for (int c = 0; c < 2; c++) begin
      ended[c] = prev[c] && !din[c];
      r[c].ch  = c[0];
      r[c].w   = run[c];
      r[c].ts  = start[c];
      if (din[c]) begin
        if (!prev[c]) begin
          run[c]   = 1;
          start[c] = cyc;
        end else begin
          run[c]++;
        end
      end else begin
        run[c] = 0;
      end
      prev[c] = din[c];
    end
    if (do_pop) void'(q.pop_front());
    dropped = 0;
    for (int c = 0; c < 2; c++) begin
      if (ended[c]) begin
        if (q.size() < DEPTH) q.push_back(r[c]);
        else dropped = 1;
      end
    end
    if (dropped) m_ovf = 1;
    else if (clr_ovf) m_ovf = 0;
    cyc++;
  endtask

  task automatic compare();
    rec_t h;
    bit   v;
    v = (q.size() > 0);
    h.ch = 0; h.w = 0; h.ts = 0;
    if (v) h = q[0];
    check("valid_a", valid_a, v);
    check("ch_a",    ch_a,    h.ch);
    check("width_a", w_a,     sat(h.w, 65535));
    check("ovf_a",   ovf_a,   m_ovf);
    check("valid_b", valid_b, v);
    check("ch_b",    ch_b,    h.ch);
    check("width_b", w_b,     sat(h.w, 15));
    check("ovf_b",   ovf_b,   m_ovf);
`ifdef PULSE_MEAS_TIMESTAMP_EN
    check("ts_a", ts_a, h.ts & 16'hffff);
    check("ts_b", ts_b, h.ts & 4'hf);
`endif
  endtask

  task automatic step(input logic [1:0] d, input logic rdy, input logic clr, input logic r);
    din = d; rec_ready = rdy; clr_ovf = clr; rst = r;
    @(posedge clk);
    model_update();
    #1;
    compare();
  endtask

  int hold [2];
  logic [1:0] rd;

  initial begin
    din = 2'b00; rec_ready = 1'b0; clr_ovf = 1'b0; rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      run[c] = 0; prev[c] = 0; start[c] = 0;
    end
    cyc = 0; m_ovf = 0;

    // Reset state
    step(2'b00, 0, 0, 1);
    step(2'b00, 0, 0, 1);
    check("rst_valid", valid_a, 1'b0);
    check("rst_width", w_a, 16'd0);
    check("rst_ovf",   ovf_a, 1'b0);

    // Long pulse on ch0, rising 10 cycles after reset
    for (int i = 0; i < 10; i++) step(2'b00, 1, 0, 0);
    for (int i = 0; i < 1000; i++) step(2'b01, 1, 0, 0);
    step(2'b00, 1, 0, 0);
    check("long_valid", valid_a, 1'b1);
    check("long_ch",    ch_a, 1'b0);
    check("long_width", w_a, 16'd1000);
    check("long_sat4",  w_b, 4'd15);
`ifdef PULSE_MEAS_TIMESTAMP_EN
    check("long_ts", ts_a, 16'd10);
`endif
    step(2'b00, 1, 0, 0);
    check("long_popped", valid_a, 1'b0);

    // Simultaneous falls: ch1 high 7, ch0 high 5, held with ready low
    step(2'b10, 0, 0, 0);
    step(2'b10, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(2'b11, 0, 0, 0);
    step(2'b00, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(2'b00, 0, 0, 0);
    check("simul_first_ch", ch_a, 1'b0);
    check("simul_first_w",  w_a, 16'd5);
    step(2'b00, 1, 0, 0);
    check("simul_second_ch", ch_a, 1'b1);
    check("simul_second_w",  w_a, 16'd7);
    step(2'b00, 1, 0, 0);

    // Overflow: five ch0 pulses into a four-deep FIFO, then clear and drain
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < k + 2; i++) step(2'b01, 0, 0, 0);
      step(2'b00, 0, 0, 0);
      step(2'b00, 0, 0, 0);
    end
    check("ovf_set", ovf_a, 1'b1);
    step(2'b00, 0, 1, 0);
    check("ovf_clr", ovf_a, 1'b0);
    for (int i = 0; i < 6; i++) step(2'b00, 1, 0, 0);

    // Reset mid-pulse on ch1 with din held high
    for (int i = 0; i < 5; i++) step(2'b10, 1, 0, 0);
    step(2'b10, 1, 0, 1);
    for (int i = 0; i < 8; i++) step(2'b10, 1, 0, 0);
    step(2'b00, 1, 0, 0);
    check("rst_mid_ch", ch_a, 1'b1);
    check("rst_mid_w",  w_a, 16'd8);
    step(2'b00, 1, 0, 0);

    // Randomised traffic: phases with mostly-ready and mostly-stalled consumers
    hold[0] = 1; hold[1] = 1;
    rd = 2'b00;
    for (int n = 0; n < 6000; n++) begin
      for (int c = 0; c < 2; c++) begin
        hold[c]--;
        if (hold[c] <= 0) begin
          rd[c]   = ~rd[c];
          hold[c] = $urandom_range(1, 24);
        end
      end
      step(rd,
           ((n / 1000) % 2 == 0) ? ($urandom % 4 != 0) : ($urandom % 4 == 0),
           ($urandom % 16 == 0),
           ($urandom % 700 == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_meas.md
PULSE_MEAS -- requirements
Module: pulse_meas

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of pulse-width and timestamp fields.
REQ-002 SHALL have parameter DEPTH, default 4, record FIFO depth; power of two, at least 2.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port din  input  2  per-channel level inputs, one bit per upstream `sub` output, synchronous to clk.
REQ-006 SHALL have port rec_valid  output  1  FIFO head record is valid.
REQ-007 SHALL have port rec_ready  input  1  consumer accepts head record.
REQ-008 SHALL have port rec_ch  output  1  channel index of the head record.
REQ-009 SHALL have port rec_width  output  CNT_W  high time of the head record, in clk cycles.
REQ-010 SHALL have port ovf  output  1  sticky flag: a record was dropped.
REQ-011 SHALL have port clr_ovf  input  1  clears ovf.

Function
REQ-012 SHALL register din into d1 every cycle; rise = din & ~d1, fall = ~din & d1, per channel.
REQ-013 SHALL run an independent 2-state FSM per channel: IDLE and HIGH.
REQ-014 IDLE: on rise, go to HIGH and load cnt = 1; otherwise hold.
REQ-015 HIGH: while din = 1, cnt += 1, saturating at 2^CNT_W-1 (no wrap); on din = 0, push {ch, cnt} and return to IDLE.
REQ-016 A record SHALL equal the number of cycles din was sampled high; a 1-cycle pulse gives width 1.
REQ-017 A record pushed in cycle N SHALL appear at rec_valid/rec_ch/rec_width in cycle N+1 when the FIFO was empty (1-cycle latency).
REQ-018 The FIFO SHALL accept up to 2 pushes per cycle; on simultaneous ends, ch0 SHALL be ordered ahead of ch1.
REQ-019 A pop SHALL occur on rec_valid & rec_ready; free space for same-cycle pushes SHALL count that pop.
REQ-020 When space is insufficient, records that do not fit SHALL be dropped (ch1 first) and ovf set the next cycle; stored records SHALL be unaffected.
REQ-021 clr_ovf SHALL clear ovf; if a drop occurs in the same cycle, set SHALL win.
REQ-022 rec_ch and rec_width SHALL hold stable while rec_valid & ~rec_ready.
REQ-023 While rec_valid = 0, rec_ch and rec_width SHALL be 0.

Reset
REQ-024 On rst sampled high, d1, cnt, FIFO pointers and occupancy, and ovf SHALL clear to 0, and both FSMs SHALL go to IDLE.
REQ-025 After reset, rec_valid = 0, rec_ch = 0, rec_width = 0, ovf = 0.
REQ-026 A pulse in progress at reset SHALL be discarded; no record SHALL be produced for it.
REQ-027 din = 1 in the first cycle after reset SHALL count as a rise, because d1 = 0.

Configuration
REQ-028 Macro PULSE_MEAS_TIMESTAMP_EN SHALL control the timestamp feature.
REQ-029 With the macro defined: add output rec_ts (CNT_W) carrying a free-running, wrapping cycle counter (0 at reset) captured on rise; it SHALL be stored per record and follow the rec_width rules.
REQ-030 Without the macro: rec_ts and its counter SHALL be absent, and behaviour is otherwise identical.

Verification (CNT_W=16, DEPTH=4 unless stated)
REQ-031 Drive din[0] high 1000 cycles with rec_ready = 1 -> one record, ch=0, width=1000, valid 1 cycle after the fall.
REQ-032 Drive din[0] high 5 cycles and din[1] high 7 cycles, both falling in the same cycle -> records {ch0,5} then {ch1,7}, in that order.
REQ-033 Hold rec_ready = 0 and send 5 ch0 pulses -> 4 records held, ovf = 1, 5th dropped; pulse clr_ovf -> ovf = 0; drain -> widths in order.
REQ-034 With CNT_W = 4, drive a 20-cycle pulse -> width = 15 (saturated).
REQ-035 Assert rst mid-pulse on ch1 and keep din high -> no record for that pulse; the first record after reset counts from the first post-reset cycle.
REQ-036 With PULSE_MEAS_TIMESTAMP_EN defined, rise 10 cycles after reset -> rec_ts = 10; with rec_ready low 3 cycles, all outputs stay stable.
